// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Definitions shared by the FPU operation dispatcher and its helpers:
//   - disp_state_e : dispatcher controller states
//   - QNAN32/QNAN64: canonical quiet NaN words for binary32 / binary64
//   - is_nan()     : NaN test for a word with a given exponent/significand
//                    split (exponent all ones and fraction nonzero)
// ---------------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE,
    ST_RELEASE
  } disp_state_e;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

  // The word is passed zero-extended to 64 bits so one function serves both
  // formats; ew/sw are elaboration constants, so the loop folds to plain gates.
  function automatic logic is_nan(input logic [63:0] word,
                                  input int          ew,
                                  input int          sw);
    logic exp_ones;
    logic frac_nz;
    exp_ones = 1'b1;
    frac_nz  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < sw) begin
        frac_nz = frac_nz | word[i];
      end else if (i < sw + ew) begin
        exp_ones = exp_ones & word[i];
      end
    end
    return exp_ones & frac_nz;
  endfunction

endpackage

// File: rtl/fpu_nan_screen.sv
// ---------------------------------------------------------------------------
// fpu_nan_screen
// Combinational screen applied to the operands and unit select at the point
// they are latched. A request is short-circuited when either operand is a NaN
// or the select addresses a unit that does not exist.
//   data_x_i, data_y_i : operands (W bits)
//   sel_i              : unit select (UW bits)
//   short_o            : 1 = do not launch any unit, answer with canonical qNaN
// ---------------------------------------------------------------------------
module fpu_nan_screen
  import fpu_pkg::*;
#(
  parameter int W       = 64,
  parameter int EW      = 11,
  parameter int SW      = 52,
  parameter int N_UNITS = 3,
  parameter int UW      = $clog2(N_UNITS)
) (
  input  logic [W-1:0]  data_x_i,
  input  logic [W-1:0]  data_y_i,
  input  logic [UW-1:0] sel_i,
  output logic          short_o
);

  logic nan_any;
  logic bad_sel;

  always_comb begin
    nan_any = is_nan(64'(data_x_i), EW, SW) | is_nan(64'(data_y_i), EW, SW);
    bad_sel = (32'(sel_i) >= N_UNITS);
    short_o = nan_any | bad_sel;
  end

endmodule

// File: rtl/fpu_op_dispatcher.sv
// ---------------------------------------------------------------------------
// fpu_op_dispatcher
// Registered, single-outstanding-operation controller between the FPU host
// port and N_UNITS execution units. A request is latched in IDLE, screened
// for NaN operands / invalid select, then exactly one unit gets a one-cycle
// start pulse. The unit's result and flags are captured into held outputs,
// presented with operation_ready until the host acks, and the unit is then
// released with a one-cycle unit_ack pulse.
//
// Host side : clk, rst (async, active high), begin_operation, ack_operation,
//             operation[UW:1] unit select / [0] sub-mode, r_mode, Data_1/2,
//             busy, operation_ready, op_result, overflow_flag,
//             underflow_flag, NaN_flag, timeout_flag
// Unit side : unit_beg, unit_ack (one-hot pulses), unit_op, unit_r_mode,
//             unit_data_x/y (latched, held), unit_ready, unit_result
//             (unit k at [k*W +: W]), unit_overflow, unit_underflow
//
// Build option: FPU_DISPATCH_WATCHDOG_EN adds a WAIT-state watchdog that
// aborts after TIMEOUT cycles with a qNaN result and timeout_flag set.
// Without it, WAIT is unbounded and timeout_flag is tied low.
// ---------------------------------------------------------------------------
module fpu_op_dispatcher
  import fpu_pkg::*;
#(
  parameter int W       = 64,
  parameter int EW      = 11,
  parameter int SW      = 52,
  parameter int N_UNITS = 3,
  parameter int UW      = $clog2(N_UNITS),
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   begin_operation,
  input  logic                   ack_operation,
  input  logic [UW:0]            operation,
  input  logic [1:0]             r_mode,
  input  logic [W-1:0]           Data_1,
  input  logic [W-1:0]           Data_2,
  output logic [N_UNITS-1:0]     unit_beg,
  output logic [N_UNITS-1:0]     unit_ack,
  output logic                   unit_op,
  output logic [1:0]             unit_r_mode,
  output logic [W-1:0]           unit_data_x,
  output logic [W-1:0]           unit_data_y,
  input  logic [N_UNITS-1:0]     unit_ready,
  input  logic [N_UNITS*W-1:0]   unit_result,
  input  logic [N_UNITS-1:0]     unit_overflow,
  input  logic [N_UNITS-1:0]     unit_underflow,
  output logic                   busy,
  output logic                   operation_ready,
  output logic [W-1:0]           op_result,
  output logic                   overflow_flag,
  output logic                   underflow_flag,
  output logic                   NaN_flag,
  output logic                   timeout_flag
);

  // Canonical quiet NaN {0, EW ones, 1, SW-1 zeros} for the configured width.
  localparam logic [63:0]  QNAN_SEL = (W == 32) ? {32'h0, QNAN32} : QNAN64;
  localparam logic [W-1:0] QNAN     = QNAN_SEL[W-1:0];

  disp_state_e state_q, state_d;

  logic [UW:0]          op_q;
  logic [1:0]           r_mode_q;
  logic [W-1:0]         x_q, y_q;
  logic                 launched_q;
  logic [W-1:0]         result_q;
  logic                 ov_q, uf_q, nan_q;

  logic                 short_req;
  logic [N_UNITS-1:0]   sel_oh;
  logic                 ready_hit;
  logic [W-1:0]         sel_result;
  logic                 sel_ov, sel_uf;
  logic                 timeout_hit;

  // Screen the values about to be latched so a short-circuit lands in DONE
  // one cycle after the request.
  fpu_nan_screen #(
    .W       (W),
    .EW      (EW),
    .SW      (SW),
    .N_UNITS (N_UNITS),
    .UW      (UW)
  ) u_nan_screen (
    .data_x_i (Data_1),
    .data_y_i (Data_2),
    .sel_i    (operation[UW:1]),
    .short_o  (short_req)
  );

  // Unit selection from the latched select. An out-of-range select shifts
  // the single one off the top, so no unit is ever addressed.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned; that is what keeps latches from appearing.
    sel_oh     = N_UNITS'(1) << op_q[UW:1];
    sel_result = '0;
    sel_ov     = 1'b0;
    sel_uf     = 1'b0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (sel_oh[k]) begin
        sel_result = sel_result | unit_result[k*W +: W];
        sel_ov     = sel_ov | unit_overflow[k];
        sel_uf     = sel_uf | unit_underflow[k];
      end
    end
    ready_hit = |(unit_ready & sel_oh);
  end

`ifdef FPU_DISPATCH_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_q;
  logic          timeout_q;

  // A ready arriving on the last allowed cycle still wins over the abort.
  assign timeout_hit = (state_q == ST_WAIT) && !ready_hit &&
                       (wd_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_LAUNCH) begin
        wd_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wd_cnt_q <= wd_cnt_q + CW'(1);
      end
      if (state_q == ST_IDLE && begin_operation) begin
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_flag = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. begin_operation matters only in IDLE and
  // ack_operation only in DONE; a ready and ack together in WAIT just
  // reaches DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (begin_operation) begin
          state_d = short_req ? ST_DONE : ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ready_hit || timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack_operation) begin
          state_d = launched_q ? ST_RELEASE : ST_IDLE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request latch and result capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so the unit buses and the held
    // result read zero straight out of reset instead of stale data.
    if (rst) begin
      op_q       <= '0;
      r_mode_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      launched_q <= 1'b0;
      result_q   <= '0;
      ov_q       <= 1'b0;
      uf_q       <= 1'b0;
      nan_q      <= 1'b0;
    end else if (state_q == ST_IDLE && begin_operation) begin
      op_q       <= operation;
      r_mode_q   <= r_mode;
      x_q        <= Data_1;
      y_q        <= Data_2;
      launched_q <= !short_req;
      if (short_req) begin
        result_q <= QNAN;
        ov_q     <= 1'b0;
        uf_q     <= 1'b0;
        nan_q    <= 1'b1;
      end
    end else if (state_q == ST_WAIT) begin
      if (ready_hit) begin
        result_q <= sel_result;
        ov_q     <= sel_ov;
        uf_q     <= sel_uf;
        nan_q    <= 1'b0;
      end else if (timeout_hit) begin
        result_q <= QNAN;
        ov_q     <= 1'b0;
        uf_q     <= 1'b0;
        nan_q    <= 1'b1;
      end
    end
  end

  // Outputs are decoded from registered state only, so pulses are exactly
  // one state long and drop with the asynchronous reset.
  always_comb begin
    unit_beg        = (state_q == ST_LAUNCH)  ? sel_oh : '0;
    unit_ack        = (state_q == ST_RELEASE) ? sel_oh : '0;
    busy            = (state_q != ST_IDLE);
    operation_ready = (state_q == ST_DONE);
  end

  assign unit_op        = op_q[0];
  assign unit_r_mode    = r_mode_q;
  assign unit_data_x    = x_q;
  assign unit_data_y    = y_q;
  assign op_result      = result_q;
  assign overflow_flag  = ov_q;
  assign underflow_flag = uf_q;
  assign NaN_flag       = nan_q;

endmodule

// File: tb/tb_fpu_op_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_dispatcher
// Self-checking bench for fpu_op_dispatcher (W=64, N_UNITS=3). Unit behaviour
// is played by the bench; expected results come from the dispatcher's rules:
// NaN operand or select >= N_UNITS gives the canonical qNaN with no unit
// touched, otherwise the selected unit's result and flags are returned.
// Define FPU_DISPATCH_WATCHDOG_EN for both DUT and bench to run the watchdog
// scenario (TIMEOUT=15).
// ---------------------------------------------------------------------------
module tb_fpu_op_dispatcher;

  localparam int W  = 64;
  localparam int EW = 11;
  localparam int SW = 52;
  localparam int N  = 3;
  localparam int UW = 2;
  localparam int TO = 15;
  localparam logic [63:0] REF_QNAN = 64'h7FF8_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             begin_operation;
  logic             ack_operation;
  logic [UW:0]      operation;
  logic [1:0]       r_mode;
  logic [W-1:0]     Data_1, Data_2;
  logic [N-1:0]     unit_beg, unit_ack;
  logic             unit_op;
  logic [1:0]       unit_r_mode;
  logic [W-1:0]     unit_data_x, unit_data_y;
  logic [N-1:0]     unit_ready;
  logic [N*W-1:0]   unit_result;
  logic [N-1:0]     unit_overflow, unit_underflow;
  logic             busy, operation_ready;
  logic [W-1:0]     op_result;
  logic             overflow_flag, underflow_flag, NaN_flag, timeout_flag;

  int checks = 0;
  int errors = 0;

  fpu_op_dispatcher #(
    .W (W), .EW (EW), .SW (SW), .N_UNITS (N), .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .begin_operation (begin_operation),
    .ack_operation   (ack_operation),
    .operation       (operation),
    .r_mode          (r_mode),
    .Data_1          (Data_1),
    .Data_2          (Data_2),
    .unit_beg        (unit_beg),
    .unit_ack        (unit_ack),
    .unit_op         (unit_op),
    .unit_r_mode     (unit_r_mode),
    .unit_data_x     (unit_data_x),
    .unit_data_y     (unit_data_y),
    .unit_ready      (unit_ready),
    .unit_result     (unit_result),
    .unit_overflow   (unit_overflow),
    .unit_underflow  (unit_underflow),
    .busy            (busy),
    .operation_ready (operation_ready),
    .op_result       (op_result),
    .overflow_flag   (overflow_flag),
    .underflow_flag  (underflow_flag),
    .NaN_flag        (NaN_flag),
    .timeout_flag    (timeout_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "time limit");
  end

  // IEEE-754 binary64 NaN: exponent all ones, fraction nonzero.
  function automatic bit ref_is_nan(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete host transaction with the bench acting as the units.
  task automatic do_op(input int sel, input logic [63:0] x, input logic [63:0] y,
                       input int delay, input logic [63:0] res, input bit ov,
                       input bit uf, input int hold, input bit beg_in_wait,
                       input bit ack_with_ready, input bit noise);
    bit            short_c;
    logic [N-1:0]  oh;
    logic [63:0]   exp_res;
    bit            exp_ov, exp_uf, exp_nan;
    logic [1:0]    rm;
    bit            subop;
    logic [N*W-1:0] bus;
    logic [N-1:0]  fl;

    short_c = (sel >= N) || ref_is_nan(x) || ref_is_nan(y);
    oh      = short_c ? '0 : (N'(1) << sel);
    exp_res = short_c ? REF_QNAN : res;
    exp_ov  = short_c ? 1'b0 : ov;
    exp_uf  = short_c ? 1'b0 : uf;
    exp_nan = short_c;
    rm      = 2'($urandom_range(0, 3));
    subop   = 1'($urandom_range(0, 1));

    operation       = {2'(sel), subop};
    r_mode          = rm;
    Data_1          = x;
    Data_2          = y;
    begin_operation = 1'b1;
    tick();
    begin_operation = 1'b0;
    Data_1          = rand64();
    Data_2          = rand64();

    if (short_c) begin
      checks++; if (operation_ready !== 1'b1) begin errors++; $display("FAIL short_ready_cycle1: got %b expected 1", operation_ready); end
      checks++; if (unit_beg !== 3'b000) begin errors++; $display("FAIL short_no_beg: got %b expected 000", unit_beg); end
    end else begin
      checks++; if (unit_beg !== oh) begin errors++; $display("FAIL launch_beg: got %b expected %b", unit_beg, oh); end
      checks++; if (busy !== 1'b1 || operation_ready !== 1'b0) begin errors++; $display("FAIL launch_status: got busy=%b ready=%b expected busy=1 ready=0", busy, operation_ready); end
      checks++; if (unit_data_x !== x || unit_data_y !== y) begin errors++; $display("FAIL launch_operands: got %h %h expected %h %h", unit_data_x, unit_data_y, x, y); end
      checks++; if (unit_op !== subop || unit_r_mode !== rm) begin errors++; $display("FAIL launch_controls: got op=%b rm=%b expected op=%b rm=%b", unit_op, unit_r_mode, subop, rm); end

      for (int i = 0; i < delay; i++) begin
        if (noise) begin
          unit_ready = N'($urandom) & ~oh;
          for (int k = 0; k < 6; k++) bus[k*32 +: 32] = $urandom;
          unit_result = bus;
        end
        if (beg_in_wait && i == 1) begin
          begin_operation = 1'b1;
          operation       = {2'($urandom_range(0, 2)), 1'b0};
          Data_1          = ~x;
        end
        tick();
        begin_operation = 1'b0;
        checks++; if (unit_beg !== 3'b000 || operation_ready !== 1'b0) begin errors++; $display("FAIL wait_quiet: got beg=%b ready=%b expected beg=000 ready=0", unit_beg, operation_ready); end
        checks++; if (unit_data_x !== x) begin errors++; $display("FAIL wait_operand_hold: got %h expected %h", unit_data_x, x); end
      end

      for (int k = 0; k < 6; k++) bus[k*32 +: 32] = $urandom;
      bus[sel*W +: W] = res;
      unit_result     = bus;
      fl = N'($urandom); fl[sel] = ov; unit_overflow  = fl;
      fl = N'($urandom); fl[sel] = uf; unit_underflow = fl;
      unit_ready      = (noise ? N'($urandom) : '0) | oh;
      if (ack_with_ready) ack_operation = 1'b1;
      tick();
      unit_ready    = '0;
      ack_operation = 1'b0;
      unit_result   = ~bus;
      if (ack_with_ready) begin
        tick();
        checks++; if (operation_ready !== 1'b1 || unit_ack !== 3'b000) begin errors++; $display("FAIL ack_during_wait_ignored: got ready=%b uack=%b expected ready=1 uack=000", operation_ready, unit_ack); end
      end
    end

    checks++; if (operation_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL done_status: got ready=%b busy=%b expected 1 1", operation_ready, busy); end
    checks++; if (op_result !== exp_res) begin errors++; $display("FAIL done_result: got %h expected %h", op_result, exp_res); end
    checks++; if ({overflow_flag, underflow_flag, NaN_flag, timeout_flag} !== {exp_ov, exp_uf, exp_nan, 1'b0}) begin
      errors++; $display("FAIL done_flags: got ov=%b uf=%b nan=%b to=%b expected ov=%b uf=%b nan=%b to=0",
                         overflow_flag, underflow_flag, NaN_flag, timeout_flag, exp_ov, exp_uf, exp_nan);
    end

    for (int i = 0; i < hold; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        begin_operation = 1'b1;
        Data_1          = rand64();
      end
      tick();
      begin_operation = 1'b0;
      checks++; if (operation_ready !== 1'b1 || op_result !== exp_res || unit_beg !== 3'b000) begin
        errors++; $display("FAIL done_hold: got ready=%b result=%h beg=%b expected ready=1 result=%h beg=000", operation_ready, op_result, unit_beg, exp_res);
      end
    end

    ack_operation = 1'b1;
    tick();
    ack_operation = 1'b0;
    checks++; if (operation_ready !== 1'b0 || unit_ack !== oh) begin errors++; $display("FAIL ack_release: got ready=%b uack=%b expected ready=0 uack=%b", operation_ready, unit_ack, oh); end
    checks++; if (busy !== !short_c) begin errors++; $display("FAIL ack_busy: got %b expected %b", busy, !short_c); end
    if (!short_c) begin
      tick();
      checks++; if (unit_ack !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL release_end: got uack=%b busy=%b expected 000 0", unit_ack, busy); end
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    begin_operation = 1'b0;
    ack_operation   = 1'b0;
    operation       = '0;
    r_mode          = '0;
    Data_1          = '0;
    Data_2          = '0;
    unit_ready      = '0;
    unit_result     = '0;
    unit_overflow   = '0;
    unit_underflow  = '0;
    #1;
    tick();
    tick();
    checks++; if (busy !== 1'b0 || operation_ready !== 1'b0) begin errors++; $display("FAIL reset_status: got busy=%b ready=%b expected 0 0", busy, operation_ready); end
    checks++; if (op_result !== 64'd0 || {overflow_flag, underflow_flag, NaN_flag, timeout_flag} !== 4'b0000) begin errors++; $display("FAIL reset_result: got %h flags=%b expected 0 0000", op_result, {overflow_flag, underflow_flag, NaN_flag, timeout_flag}); end
    checks++; if (unit_beg !== 3'b000 || unit_ack !== 3'b000 || unit_data_x !== 64'd0 || unit_data_y !== 64'd0 || unit_op !== 1'b0 || unit_r_mode !== 2'b00) begin
      errors++; $display("FAIL reset_unit_bus: got beg=%b ack=%b x=%h y=%h expected all zero", unit_beg, unit_ack, unit_data_x, unit_data_y);
    end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_mult_directed();
    do_op(2, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 5,
          64'h4018_0000_0000_0000, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_nan_short();
    do_op(1, 64'h7FF8_0000_0000_0001, 64'h3FF0_0000_0000_0000, 0, '0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    do_op(0, 64'h3FF0_0000_0000_0000, 64'hFFF0_0000_0000_0001, 0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_select();
    do_op(3, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 0, '0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_infinity_not_nan();
    do_op(0, 64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 2,
          64'h7FF8_0000_0000_0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_begin_during_wait();
    do_op(1, 64'h3FF8_0000_0000_0000, 64'h4010_0000_0000_0000, 4,
          64'h4018_0000_0000_0000, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ready_ack_same_cycle();
    do_op(2, 64'h4024_0000_0000_0000, 64'h3FE0_0000_0000_0000, 2,
          64'h4014_0000_0000_0000, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_operation();
    operation       = {2'd1, 1'b0};
    Data_1          = 64'h4000_0000_0000_0000;
    Data_2          = 64'h4000_0000_0000_0000;
    begin_operation = 1'b1;
    tick();
    begin_operation = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b1 || operation_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_wait: got busy=%b ready=%b expected 1 0", busy, operation_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || operation_ready !== 1'b0 || unit_beg !== 3'b000 || unit_ack !== 3'b000) begin errors++; $display("FAIL midrst_status: got busy=%b ready=%b beg=%b ack=%b expected all 0", busy, operation_ready, unit_beg, unit_ack); end
    checks++; if (op_result !== 64'd0 || unit_data_x !== 64'd0 || NaN_flag !== 1'b0) begin errors++; $display("FAIL midrst_clear: got result=%h x=%h nan=%b expected 0", op_result, unit_data_x, NaN_flag); end
    #3 rst = 1'b0;
    tick();
    do_op(1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 3,
          64'h4010_0000_0000_0000, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int          sel, kind, dly;
      logic [63:0] x, y;
      sel  = $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      x    = rand64();
      y    = rand64();
      if (kind == 0) x = {1'($urandom), 11'h7FF, 52'd1 << $urandom_range(0, 51)};
      if (kind == 1) y = {1'($urandom), 11'h7FF, 20'($urandom), 32'($urandom) | 32'd1};
      if (kind == 2) x = {1'($urandom), 11'h7FF, 52'd0};
      dly = $urandom_range(1, 7);
      do_op(sel, x, y, dly, rand64(), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2), (dly >= 2) && ($urandom_range(0, 1) == 1),
            1'b0, 1'b1);
    end
  endtask

`ifdef FPU_DISPATCH_WATCHDOG_EN
  task automatic test_watchdog();
    int cycles;
    operation       = {2'd0, 1'b1};
    Data_1          = 64'h4000_0000_0000_0000;
    Data_2          = 64'h4000_0000_0000_0000;
    begin_operation = 1'b1;
    tick();
    begin_operation = 1'b0;
    cycles = 0;
    while (operation_ready !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    // LAUNCH -> WAIT edge plus TIMEOUT WAIT cycles.
    checks++; if (cycles != TO + 1) begin errors++; $display("FAIL wd_latency: got %0d cycles expected %0d", cycles, TO + 1); end
    checks++; if (op_result !== REF_QNAN || timeout_flag !== 1'b1 || NaN_flag !== 1'b1) begin errors++; $display("FAIL wd_result: got %h to=%b nan=%b expected %h 1 1", op_result, timeout_flag, NaN_flag, REF_QNAN); end
    ack_operation = 1'b1;
    tick();
    ack_operation = 1'b0;
    checks++; if (unit_ack !== 3'b001) begin errors++; $display("FAIL wd_release: got %b expected 001", unit_ack); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got busy=%b expected 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult_directed();
    test_nan_short();
    test_bad_select();
    test_infinity_not_nan();
    test_begin_during_wait();
    test_ready_ack_same_cycle();
    test_reset_mid_operation();
    test_random();
`ifdef FPU_DISPATCH_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
